prbs_ber_sequencer: RTL and testbench

Run controller for a bit-error-rate (BER) test built around a PRBS checker.
- Consumes the received word and the checker's predicted word for each beat.
- Sequences the test: idle, lock acquisition, error counting over a programmed word count, done.
- Accumulates word and bit-error counts and reports lock / loss-of-lock status to the control/AXI-lite layer.

---
 rtl/prbs_ber_sequencer_pkg.sv | 31 +++
 rtl/prbs_ber_sequencer_if.sv | 24 ++
 rtl/prbs_popcount32.sv | 14 +
 rtl/prbs_ber_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_prbs_ber_sequencer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_ber_sequencer_pkg.sv
// Shared types for the PRBS BER run controller: state encoding, widths and the
// fixed-width part of the control register.
package prbs_ber_pkg;

  localparam int CNT_W_DEFAULT = 48;
  localparam int MATCH_W       = 16;
  localparam int ERR_W         = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_COUNT   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Word/error counters and the target live beside this struct because their
  // width follows the CNT_W parameter of each instance.
  typedef struct packed {
    state_e             state;
    logic [MATCH_W-1:0] match_cnt;
    logic [MATCH_W-1:0] los_cnt;
    logic               lock_lost;
    logic               p_valid;
    logic [ERR_W-1:0]   p_err;
  } ctrl_s;

  function automatic logic is_busy(input state_e s);
    return (s == ST_ACQUIRE) || (s == ST_COUNT);
  endfunction

endpackage

// File: rtl/prbs_ber_sequencer_if.sv
// Received-stream bundle: received word, aligned predicted word, valid/ready.
interface prbs_ber_sequencer_if;
  // A beat transfers on a clock edge where S_AXIS_TVALID && S_AXIS_TREADY; the
  // sequencer holds TREADY at 1, so every TVALID cycle is a beat and the source
  // never stalls. PRED_TDATA is qualified by the same TVALID.
  logic [31:0] S_AXIS_TDATA;
  logic [31:0] PRED_TDATA;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TREADY;

  modport master (
    output S_AXIS_TDATA,
    output PRED_TDATA,
    output S_AXIS_TVALID,
    input  S_AXIS_TREADY
  );

  modport slave (
    input  S_AXIS_TDATA,
    input  PRED_TDATA,
    input  S_AXIS_TVALID,
    output S_AXIS_TREADY
  );
endinterface

// File: rtl/prbs_popcount32.sv
// Combinational population count of a 32-bit word (0..32, 6-bit result).
module prbs_popcount32 (
  input  logic [31:0] data_i,
  output logic [5:0]  count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < 32; i++) begin
      count_o = count_o + {5'd0, data_i[i]};
    end
  end

endmodule

// File: rtl/prbs_ber_sequencer.sv
// BER test run controller: IDLE -> ACQUIRE -> COUNT -> DONE with saturating word
// and bit-error counters. Optional first-error log under PRBS_BER_ERRLOG_EN.
module prbs_ber_sequencer
  import prbs_ber_pkg::*;
#(
  parameter int LOCK_THRESHOLD = 16,
  parameter int LOS_THRESHOLD  = 4,
  parameter int CNT_W          = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     test_words,
  prbs_ber_sequencer_if.slave  axis,
  output logic                 busy,
  output logic                 locked,
  output logic                 done,
  output logic                 lock_lost,
  output logic [CNT_W-1:0]     word_count,
  output logic [CNT_W-1:0]     error_count,
  output logic [1:0]           state_dbg
`ifdef PRBS_BER_ERRLOG_EN
  ,
  output logic                 first_err_valid,
  output logic [CNT_W-1:0]     first_err_index,
  output logic [31:0]          first_err_xor
`endif
);

  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

  ctrl_s            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] wc_q, wc_d;
  logic [CNT_W-1:0] ec_q, ec_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;

  logic [31:0]      xor_w;
  logic [ERR_W-1:0] pop_w;
  logic [CNT_W:0]   wc_inc;
  logic [CNT_W:0]   ec_sum;
  logic             hit_done;
  logic             lose;

`ifdef PRBS_BER_ERRLOG_EN
  logic [31:0]      p_xor_q, p_xor_d;
  logic             fe_valid_q, fe_valid_d;
  logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
  logic [31:0]      fe_xor_q, fe_xor_d;
`endif

  assign xor_w = axis.S_AXIS_TDATA ^ axis.PRED_TDATA;

  prbs_popcount32 u_popcount (
    .data_i  (xor_w),
    .count_o (pop_w)
  );

  assign axis.S_AXIS_TREADY = 1'b1;

  // Extra top bit flags that the counter was already all-ones (saturation).
  assign wc_inc   = {1'b0, wc_q} + (CNT_W+1)'(1);
  assign ec_sum   = {1'b0, ec_q} + (CNT_W+1)'(ctrl_q.p_err);
  assign hit_done = (tgt_q != '0) && (wc_inc == {1'b0, tgt_q});

  always_comb begin
    ctrl_d = ctrl_q;
    wc_d   = wc_q;
    ec_d   = ec_q;
    tgt_d  = tgt_q;
    lose   = 1'b0;
`ifdef PRBS_BER_ERRLOG_EN
    p_xor_d    = axis.S_AXIS_TVALID ? xor_w : p_xor_q;
    fe_valid_d = fe_valid_q;
    fe_idx_d   = fe_idx_q;
    fe_xor_d   = fe_xor_q;
`endif

    ctrl_d.p_valid = axis.S_AXIS_TVALID;
    ctrl_d.p_err   = axis.S_AXIS_TVALID ? pop_w : '0;

    case (ctrl_q.state)
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          ctrl_d.state     = ST_ACQUIRE;
          ctrl_d.match_cnt = '0;
          ctrl_d.los_cnt   = '0;
          ctrl_d.lock_lost = 1'b0;
          wc_d             = '0;
          ec_d             = '0;
          tgt_d            = test_words;
`ifdef PRBS_BER_ERRLOG_EN
          fe_valid_d       = 1'b0;
          fe_idx_d         = '0;
          fe_xor_d         = '0;
`endif
        end
      end

      ST_ACQUIRE: begin
        if (abort) begin
          ctrl_d.state = ST_DONE;
        end else if (ctrl_q.p_valid) begin
          if (ctrl_q.p_err == '0) begin
            if (int'(ctrl_q.match_cnt) + 1 >= LOCK_THRESHOLD) begin
              ctrl_d.state     = ST_COUNT;
              ctrl_d.match_cnt = '0;
            end else begin
              ctrl_d.match_cnt = ctrl_q.match_cnt + MATCH_ONE;
            end
          end else begin
            ctrl_d.match_cnt = '0;
          end
        end
      end

      ST_COUNT: begin
        if (abort) begin
          ctrl_d.state = ST_DONE;
        end else if (ctrl_q.p_valid) begin
          wc_d = wc_inc[CNT_W] ? wc_q : wc_inc[CNT_W-1:0];
          ec_d = ec_sum[CNT_W] ? '1 : ec_sum[CNT_W-1:0];
          if (ctrl_q.p_err != '0) begin
            if (int'(ctrl_q.los_cnt) + 1 >= LOS_THRESHOLD) begin
              lose = 1'b1;
            end else begin
              ctrl_d.los_cnt = ctrl_q.los_cnt + MATCH_ONE;
            end
`ifdef PRBS_BER_ERRLOG_EN
            if (!fe_valid_q) begin
              fe_valid_d = 1'b1;
              fe_idx_d   = wc_q;
              fe_xor_d   = p_xor_q;
            end
`endif
          end else begin
            ctrl_d.los_cnt = '0;
          end
          // Reaching the target outranks a coincident loss of lock.
          if (hit_done) begin
            ctrl_d.state = ST_DONE;
          end else if (lose) begin
            ctrl_d.state     = ST_ACQUIRE;
            ctrl_d.lock_lost = 1'b1;
            ctrl_d.los_cnt   = '0;
          end
        end
      end

      default: ctrl_d.state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl_q <= '0;
      wc_q   <= '0;
      ec_q   <= '0;
      tgt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      wc_q   <= wc_d;
      ec_q   <= ec_d;
      tgt_q  <= tgt_d;
    end
  end

`ifdef PRBS_BER_ERRLOG_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      p_xor_q    <= '0;
      fe_valid_q <= 1'b0;
      fe_idx_q   <= '0;
      fe_xor_q   <= '0;
    end else begin
      p_xor_q    <= p_xor_d;
      fe_valid_q <= fe_valid_d;
      fe_idx_q   <= fe_idx_d;
      fe_xor_q   <= fe_xor_d;
    end
  end

  assign first_err_valid = fe_valid_q;
  assign first_err_index = fe_idx_q;
  assign first_err_xor   = fe_xor_q;
`endif

  assign state_dbg   = ctrl_q.state;
  assign busy        = is_busy(ctrl_q.state);
  assign locked      = (ctrl_q.state == ST_COUNT);
  assign done        = (ctrl_q.state == ST_DONE);
  assign lock_lost   = ctrl_q.lock_lost;
  assign word_count  = wc_q;
  assign error_count = ec_q;

endmodule

// File: tb/tb_prbs_ber_sequencer.sv
// Bench for prbs_ber_sequencer: a 48-bit and an 8-bit counter instance share one
// stimulus stream and are checked against a behavioural model every cycle.
module tb_prbs_ber_sequencer;

  localparam int LOCK = 16;
  localparam int LOS  = 4;
  localparam int S_IDLE = 0, S_ACQ = 1, S_CNT = 2, S_DONE = 3;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        start, abort;
  logic [47:0] test_words;

  prbs_ber_sequencer_if ax0 ();
  prbs_ber_sequencer_if ax1 ();

  logic        busy0, locked0, done0, ll0;
  logic [47:0] wc0, ec0;
  logic [1:0]  st0;
  logic        busy1, locked1, done1, ll1;
  logic [7:0]  wc1, ec1;
  logic [1:0]  st1;
`ifdef PRBS_BER_ERRLOG_EN
  logic        fev0, fev1;
  logic [47:0] fei0;
  logic [7:0]  fei1;
  logic [31:0] fex0, fex1;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  prbs_ber_sequencer #(.LOCK_THRESHOLD(LOCK), .LOS_THRESHOLD(LOS), .CNT_W(48)) dut0 (
    .clk(clk), .aresetn(aresetn), .start(start), .abort(abort),
    .test_words(test_words), .axis(ax0),
    .busy(busy0), .locked(locked0), .done(done0), .lock_lost(ll0),
    .word_count(wc0), .error_count(ec0), .state_dbg(st0)
`ifdef PRBS_BER_ERRLOG_EN
    , .first_err_valid(fev0), .first_err_index(fei0), .first_err_xor(fex0)
`endif
  );

  prbs_ber_sequencer #(.LOCK_THRESHOLD(LOCK), .LOS_THRESHOLD(LOS), .CNT_W(8)) dut1 (
    .clk(clk), .aresetn(aresetn), .start(start), .abort(abort),
    .test_words(test_words[7:0]), .axis(ax1),
    .busy(busy1), .locked(locked1), .done(done1), .lock_lost(ll1),
    .word_count(wc1), .error_count(ec1), .state_dbg(st1)
`ifdef PRBS_BER_ERRLOG_EN
    , .first_err_valid(fev1), .first_err_index(fei1), .first_err_xor(fex1)
`endif
  );

  // Behavioural model, one slot per instance; m_max is the saturation value.
  int          m_st[2];
  int          m_match[2], m_los[2];
  bit          m_ll[2];
  logic [47:0] m_wc[2], m_ec[2], m_tgt[2], m_max[2];
  bit          m_pv[2];
  int          m_perr[2];
`ifdef PRBS_BER_ERRLOG_EN
  logic [31:0] m_pxor[2];
  bit          m_fev[2];
  logic [47:0] m_fei[2];
  logic [31:0] m_fex[2];
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = S_IDLE; m_match[d] = 0; m_los[d] = 0; m_ll[d] = 0;
      m_wc[d] = '0; m_ec[d] = '0; m_tgt[d] = '0; m_pv[d] = 0; m_perr[d] = 0;
`ifdef PRBS_BER_ERRLOG_EN
      m_pxor[d] = '0; m_fev[d] = 0; m_fei[d] = '0; m_fex[d] = '0;
`endif
    end
  endtask

  task automatic model_step(input int d, input bit st, input bit ab, input bit v,
                            input logic [31:0] x);
    int nxt;
    logic [48:0] s;
    bit hit;
    nxt = m_st[d];
    if (m_st[d] == S_IDLE || m_st[d] == S_DONE) begin
      if (st && !ab) begin
        nxt = S_ACQ; m_match[d] = 0; m_los[d] = 0; m_ll[d] = 0;
        m_wc[d] = '0; m_ec[d] = '0; m_tgt[d] = test_words & m_max[d];
`ifdef PRBS_BER_ERRLOG_EN
        m_fev[d] = 0; m_fei[d] = '0; m_fex[d] = '0;
`endif
      end
    end else if (ab) begin
      nxt = S_DONE;
    end else if (m_pv[d] && m_st[d] == S_ACQ) begin
      if (m_perr[d] == 0) begin
        m_match[d]++;
        if (m_match[d] >= LOCK) begin nxt = S_CNT; m_match[d] = 0; end
      end else m_match[d] = 0;
    end else if (m_pv[d]) begin
      hit = (m_tgt[d] != 0) && ({1'b0, m_wc[d]} + 49'd1 == {1'b0, m_tgt[d]});
`ifdef PRBS_BER_ERRLOG_EN
      if (m_perr[d] != 0 && !m_fev[d]) begin
        m_fev[d] = 1; m_fei[d] = m_wc[d]; m_fex[d] = m_pxor[d];
      end
`endif
      m_wc[d] = (m_wc[d] == m_max[d]) ? m_max[d] : m_wc[d] + 48'd1;
      s = {1'b0, m_ec[d]} + 49'(m_perr[d]);
      m_ec[d] = (s > {1'b0, m_max[d]}) ? m_max[d] : s[47:0];
      if (m_perr[d] != 0) m_los[d]++; else m_los[d] = 0;
      if (hit) nxt = S_DONE;
      else if (m_los[d] >= LOS) begin nxt = S_ACQ; m_ll[d] = 1; m_los[d] = 0; end
    end
    m_st[d] = nxt;
    m_pv[d] = v;
    m_perr[d] = v ? $countones(x) : 0;
`ifdef PRBS_BER_ERRLOG_EN
    if (v) m_pxor[d] = x;
`endif
  endtask

  task automatic check_all();
    chk("state0",  64'(st0),     64'(m_st[0]));
    chk("busy0",   64'(busy0),   64'(m_st[0] == S_ACQ || m_st[0] == S_CNT));
    chk("locked0", 64'(locked0), 64'(m_st[0] == S_CNT));
    chk("done0",   64'(done0),   64'(m_st[0] == S_DONE));
    chk("lost0",   64'(ll0),     64'(m_ll[0]));
    chk("wc0",     64'(wc0),     64'(m_wc[0]));
    chk("ec0",     64'(ec0),     64'(m_ec[0]));
    chk("tready0", 64'(ax0.S_AXIS_TREADY), 64'd1);
    chk("state1",  64'(st1),     64'(m_st[1]));
    chk("busy1",   64'(busy1),   64'(m_st[1] == S_ACQ || m_st[1] == S_CNT));
    chk("locked1", 64'(locked1), 64'(m_st[1] == S_CNT));
    chk("done1",   64'(done1),   64'(m_st[1] == S_DONE));
    chk("lost1",   64'(ll1),     64'(m_ll[1]));
    chk("wc1",     64'(wc1),     64'(m_wc[1]));
    chk("ec1",     64'(ec1),     64'(m_ec[1]));
    chk("tready1", 64'(ax1.S_AXIS_TREADY), 64'd1);
`ifdef PRBS_BER_ERRLOG_EN
    chk("fev0", 64'(fev0), 64'(m_fev[0]));
    chk("fei0", 64'(fei0), 64'(m_fei[0]));
    chk("fex0", 64'(fex0), 64'(m_fex[0]));
    chk("fev1", 64'(fev1), 64'(m_fev[1]));
    chk("fei1", 64'(fei1), 64'(m_fei[1]));
    chk("fex1", 64'(fex1), 64'(m_fex[1]));
`endif
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check at the
  // next falling edge.
  task automatic beat(input bit st, input bit ab, input bit v, input logic [31:0] x);
    logic [31:0] dat;
    dat = $urandom;
    start = st; abort = ab;
    ax0.S_AXIS_TVALID = v; ax0.S_AXIS_TDATA = dat; ax0.PRED_TDATA = dat ^ x;
    ax1.S_AXIS_TVALID = v; ax1.S_AXIS_TDATA = dat; ax1.PRED_TDATA = dat ^ x;
    @(posedge clk);
    model_step(0, st, ab, v, x);
    model_step(1, st, ab, v, x);
    @(negedge clk);
    start = 0; abort = 0;
    check_all();
  endtask

  initial begin
    m_max[0] = {48{1'b1}};
    m_max[1] = 48'hFF;
    aresetn = 1'b0; start = 0; abort = 0; test_words = '0;
    ax0.S_AXIS_TVALID = 0; ax0.S_AXIS_TDATA = '0; ax0.PRED_TDATA = '0;
    ax1.S_AXIS_TVALID = 0; ax1.S_AXIS_TDATA = '0; ax1.PRED_TDATA = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    chk("reset_state", 64'(st0), 64'd0);
    aresetn = 1'b1;

    // start together with abort from IDLE is ignored
    beat(1, 1, 1, 32'd0);
    chk("start_abort_idle", 64'(st0), 64'(S_IDLE));
    beat(0, 0, 1, 32'd0);

    // clean run of 1000 words
    test_words = 48'd1000;
    beat(1, 0, 1, 32'd0);
    repeat (15) beat(0, 0, 1, 32'd0);
    chk("not_yet_locked", 64'(locked0), 64'd0);
    beat(0, 0, 1, 32'd0);
    chk("locked_after_16", 64'(locked0), 64'd1);
    repeat (1020) beat(0, 0, 1, 32'd0);
    chk("run_done", 64'(st0), 64'(S_DONE));
    chk("run_wc", 64'(wc0), 64'd1000);
    chk("run_ec", 64'(ec0), 64'd0);
    chk("run_lost", 64'(ll0), 64'd0);

    // single 2-bit error in COUNT, then loss and reacquisition
    test_words = '0;
    beat(1, 0, 1, 32'd0);
    repeat (20) beat(0, 0, 1, 32'd0);
    beat(0, 0, 1, 32'h0000_0101);
    repeat (3) beat(0, 0, 1, 32'd0);
    chk("one_err_ec", 64'(ec0), 64'd2);
    chk("one_err_locked", 64'(locked0), 64'd1);
`ifdef PRBS_BER_ERRLOG_EN
    chk("one_err_xor", 64'(fex0), 64'h101);
`endif
    repeat (4) beat(0, 0, 1, 32'hFFFF_FFFF);
    beat(0, 0, 0, 32'd0);
    chk("los_ec", 64'(ec0), 64'd130);
    chk("los_state", 64'(st0), 64'(S_ACQ));
    chk("los_flag", 64'(ll0), 64'd1);
    repeat (20) beat(0, 0, 1, 32'd0);
    chk("relock_state", 64'(st0), 64'(S_CNT));
    chk("relock_ec", 64'(ec0), 64'd130);

    // start while busy is ignored
    test_words = 48'd5;
    beat(1, 0, 1, 32'd0);
    repeat (10) beat(0, 0, 1, 32'd0);
    chk("start_busy", 64'(st0), 64'(S_CNT));

    // heavy errors without losing lock: 8-bit instance saturates
    for (int r = 0; r < 12; r++) begin
      repeat (3) beat(0, 0, 1, 32'hFFFF_FFFF);
      beat(0, 0, 1, 32'd0);
    end
    beat(0, 0, 0, 32'd0);
    chk("sat_ec1", 64'(ec1), 64'd255);
    chk("sat_ec0", 64'(ec0), 64'd1282);

    // random traffic with gaps, sparse errors, random starts and aborts
    for (int i = 0; i < 600; i++) begin
      logic [31:0] x;
      bit st, ab;
      x = ($urandom_range(0, 9) == 0) ? $urandom : 32'd0;
      st = ($urandom_range(0, 39) == 0);
      ab = ($urandom_range(0, 149) == 0);
      if (st) test_words = 48'($urandom_range(1, 300));
      beat(st, ab, $urandom_range(0, 3) != 0, x);
    end

    // free-running run ended by abort
    beat(0, 1, 1, 32'd0);
    test_words = '0;
    beat(1, 0, 1, 32'd0);
    repeat (5000) beat(0, 0, 1, 32'd0);
    beat(0, 1, 1, 32'd0);
    beat(0, 0, 1, 32'd0);
    chk("abort_done", 64'(st0), 64'(S_DONE));
    chk("abort_wc0", 64'(wc0), 64'd4984);
    chk("abort_wc1", 64'(wc1), 64'd255);

    // asynchronous reset in the middle of COUNT
    beat(1, 0, 1, 32'd0);
    repeat (24) beat(0, 0, 1, 32'h0000_0001);
    repeat (20) beat(0, 0, 1, 32'd0);
    chk("pre_reset_locked", 64'(locked0), 64'd1);
    ax0.S_AXIS_TVALID = 0; ax1.S_AXIS_TVALID = 0;
    #2 aresetn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_wc", 64'(wc0), 64'd0);
    @(negedge clk);
    aresetn = 1'b1;
    check_all();
    beat(1, 1, 1, 32'd0);
    chk("final_idle", 64'(st0), 64'(S_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
